// File: rtl/alu_exec_unit.sv
// Registered execute-stage ALU with a valid/ready handshake on both sides.
// Define ALU_ITER_SHIFT_EN to run shifts one bit per cycle instead of through a barrel shifter.
module alu_exec_unit #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       ALUControl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALUResult,
  output logic             Zero
);

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0010;
  localparam logic [3:0] OP_OR  = 4'b0011;
  localparam logic [3:0] OP_SLL = 4'b0100;
  localparam logic [3:0] OP_SLT = 4'b0101;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_SRL = 4'b0111;
  localparam logic [3:0] OP_SRA = 4'b1000;

  logic [WIDTH-1:0] result_q;
  logic             zero_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] res_d;
  logic [SHW-1:0]   amt;
  logic             accept;
  logic             xfer;

  assign amt    = SrcB[SHW-1:0];
  assign accept = in_valid && in_ready;
  assign xfer   = out_valid_q && out_ready;

  // Single-cycle result for everything the unit can finish at the accept edge.
  always_comb begin
    // NOTE: default first so every path assigns res_d and no latch is inferred.
    res_d = '0;
    case (ALUControl)
      OP_ADD: res_d = SrcA + SrcB;
      OP_SUB: res_d = SrcA - SrcB;
      OP_AND: res_d = SrcA & SrcB;
      OP_OR:  res_d = SrcA | SrcB;
      OP_XOR: res_d = SrcA ^ SrcB;
      OP_SLT: res_d = {{(WIDTH-1){1'b0}}, ($signed(SrcA) < $signed(SrcB))};
`ifdef ALU_ITER_SHIFT_EN
      // Only zero-amount shifts finish here; all others go through SHIFT.
      OP_SLL, OP_SRL, OP_SRA: res_d = SrcA;
`else
      OP_SLL: res_d = SrcA << amt;
      OP_SRL: res_d = SrcA >> amt;
      OP_SRA: res_d = $signed(SrcA) >>> amt;
`endif
      default: res_d = '0;
    endcase
  end

`ifdef ALU_ITER_SHIFT_EN
  typedef enum logic {IDLE, SHIFT} state_e;

  state_e           state_q;
  logic [SHW-1:0]   cnt_q;
  logic [WIDTH-1:0] work_q;
  logic [3:0]       op_q;
  logic [WIDTH-1:0] step_d;
  logic             is_shift;

  assign is_shift = (ALUControl == OP_SLL) || (ALUControl == OP_SRL) ||
                    (ALUControl == OP_SRA);
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);

  always_comb begin
    step_d = {work_q[WIDTH-2:0], 1'b0};
    case (op_q)
      OP_SRL:  step_d = {1'b0, work_q[WIDTH-1:1]};
      OP_SRA:  step_d = {work_q[WIDTH-1], work_q[WIDTH-1:1]};
      default: step_d = {work_q[WIDTH-2:0], 1'b0};
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
      cnt_q       <= '0;
      work_q      <= '0;
      op_q        <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (is_shift && (amt != '0)) begin
              work_q      <= SrcA;
              cnt_q       <= amt;
              op_q        <= ALUControl;
              out_valid_q <= 1'b0;
              state_q     <= SHIFT;
            end else begin
              // NOTE: non-blocking so every register sees the pre-edge values.
              result_q    <= res_d;
              zero_q      <= (res_d == '0);
              out_valid_q <= 1'b1;
            end
          end else if (xfer) begin
            out_valid_q <= 1'b0;
          end
        end
        SHIFT: begin
          work_q <= step_d;
          cnt_q  <= cnt_q - SHW'(1);
          if (cnt_q == SHW'(1)) begin
            result_q    <= step_d;
            zero_q      <= (step_d == '0);
            out_valid_q <= 1'b1;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  assign in_ready = !out_valid_q || out_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b1;
    end else if (accept) begin
      // NOTE: non-blocking so every register sees the pre-edge values.
      result_q    <= res_d;
      zero_q      <= (res_d == '0);
      out_valid_q <= 1'b1;
    end else if (xfer) begin
      out_valid_q <= 1'b0;
    end
  end
`endif

  assign out_valid = out_valid_q;
  assign ALUResult = result_q;
  assign Zero      = zero_q;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; expectations follow ALU_ITER_SHIFT_EN if defined.
module tb_alu_exec_unit;

`ifdef ALU_ITER_SHIFT_EN
  localparam bit ITER = 1'b1;
`else
  localparam bit ITER = 1'b0;
`endif

  typedef struct {
    string       name;
    logic [3:0]  ctrl;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  localparam int NV = 22;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [3:0]  ALUControl;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] ALUResult;
  logic        Zero;

  int checks = 0;
  int errors = 0;

  alu_exec_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .SrcA       (SrcA),
    .SrcB       (SrcB),
    .ALUControl (ALUControl),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .ALUResult  (ALUResult),
    .Zero       (Zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int exp_latency(input logic [3:0] ctrl, input logic [31:0] b);
    bit is_sh;
    is_sh = (ctrl == 4'b0100) || (ctrl == 4'b0111) || (ctrl == 4'b1000);
    if (ITER && is_sh && (b[4:0] != 5'd0)) return int'(b[4:0]) + 1;
    return 1;
  endfunction

  // Starts and ends on a falling edge; returns the cycles from accept edge to out_valid.
  task automatic do_op(input logic [3:0] ctrl, input logic [31:0] a, input logic [31:0] b,
                       input string name, output int lat, output bit rdy_seen);
    ALUControl = ctrl;
    SrcA       = a;
    SrcB       = b;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    #1;
    check({name, " in_ready"}, {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat      = 1;
    rdy_seen = 1'b0;
    while (!out_valid && lat < 100) begin
      if (in_ready) rdy_seen = 1'b1;
      @(negedge clk);
      lat++;
    end
  endtask

  vec_t vecs[NV];

  initial begin
    int          lat;
    bit          rdy_seen;
    logic [31:0] sa, sb, sexp;

    vecs[0]  = '{"add_wrap",   4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000};
    vecs[1]  = '{"add",        4'b0000, 32'h00000002, 32'h00000003, 32'h00000005};
    vecs[2]  = '{"sub_neg",    4'b0001, 32'h00000005, 32'h00000007, 32'hFFFFFFFE};
    vecs[3]  = '{"and",        4'b0010, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
    vecs[4]  = '{"or",         4'b0011, 32'h0F0F0000, 32'h000000F0, 32'h0F0F00F0};
    vecs[5]  = '{"xor",        4'b0110, 32'h000000F0, 32'h000000FF, 32'h0000000F};
    vecs[6]  = '{"slt_neg",    4'b0101, 32'h80000000, 32'h00000001, 32'h00000001};
    vecs[7]  = '{"slt_swap",   4'b0101, 32'h00000001, 32'h80000000, 32'h00000000};
    vecs[8]  = '{"slt_ovf",    4'b0101, 32'h7FFFFFFF, 32'h80000000, 32'h00000000};
    vecs[9]  = '{"slt_eq",     4'b0101, 32'h00000005, 32'h00000005, 32'h00000000};
    vecs[10] = '{"slt_m1",     4'b0101, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
    vecs[11] = '{"sll4",       4'b0100, 32'h00000001, 32'h00000004, 32'h00000010};
    vecs[12] = '{"sll31",      4'b0100, 32'h00000001, 32'h0000001F, 32'h80000000};
    vecs[13] = '{"srl4",       4'b0111, 32'h80000000, 32'h00000004, 32'h08000000};
    vecs[14] = '{"sra31",      4'b1000, 32'h80000000, 32'h0000001F, 32'hFFFFFFFF};
    vecs[15] = '{"sra_mask0",  4'b1000, 32'h80000000, 32'h00000020, 32'h80000000};
    vecs[16] = '{"srl0",       4'b0111, 32'h12345678, 32'h00000000, 32'h12345678};
    vecs[17] = '{"sra_pos",    4'b1000, 32'h7FFFFFFF, 32'h00000004, 32'h07FFFFFF};
    vecs[18] = '{"sll_mask1",  4'b0100, 32'h00000003, 32'h00000021, 32'h00000006};
    vecs[19] = '{"srl_out",    4'b0111, 32'h00000001, 32'h00000001, 32'h00000000};
    vecs[20] = '{"ctrl_1001",  4'b1001, 32'h12345678, 32'h00000001, 32'h00000000};
    vecs[21] = '{"ctrl_1111",  4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000};

    reset      = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    SrcA       = '0;
    SrcB       = '0;
    ALUControl = '0;
    #1;
    check("rst out_valid", {31'd0, out_valid}, 32'd0);
    check("rst ALUResult", ALUResult, 32'd0);
    check("rst Zero", {31'd0, Zero}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post-rst in_ready", {31'd0, in_ready}, 32'd1);

    for (int i = 0; i < NV; i++) begin
      do_op(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].name, lat, rdy_seen);
      check({vecs[i].name, " result"}, ALUResult, vecs[i].exp);
      check({vecs[i].name, " zero"}, {31'd0, Zero}, {31'd0, vecs[i].exp == 32'd0});
      check({vecs[i].name, " latency"}, lat, exp_latency(vecs[i].ctrl, vecs[i].b));
      if (exp_latency(vecs[i].ctrl, vecs[i].b) > 1)
        check({vecs[i].name, " in_ready low in SHIFT"}, {31'd0, rdy_seen}, 32'd0);
    end

    // Back-pressure: drain, then hold the sub result with out_ready low.
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("drain out_valid", {31'd0, out_valid}, 32'd0);
    ALUControl = 4'b0001; SrcA = 32'd5; SrcB = 32'd7;
    in_valid = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("bp out_valid", {31'd0, out_valid}, 32'd1);
      check("bp hold result", ALUResult, 32'hFFFFFFFE);
      check("bp in_ready", {31'd0, in_ready}, 32'd0);
      @(negedge clk);
    end
    ALUControl = 4'b0110; SrcA = 32'hF0; SrcB = 32'hFF;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    check("bp release in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp next out_valid", {31'd0, out_valid}, 32'd1);
    check("bp next result", ALUResult, 32'h0000000F);
    @(negedge clk);
    check("bp drop out_valid", {31'd0, out_valid}, 32'd0);

    // Streaming: ten back-to-back and/or ops, no bubbles.
    for (int i = 0; i < 10; i++) begin
      sa = 32'h0F0F_0F0F ^ (32'h1111_1111 * i);
      sb = 32'h00FF_00FF + (32'h0101_0101 * i);
      ALUControl = (i % 2 == 0) ? 4'b0010 : 4'b0011;
      sexp = (i % 2 == 0) ? (sa & sb) : (sa | sb);
      SrcA = sa; SrcB = sb;
      in_valid = 1'b1;
      #1;
      check("stream in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk);
      check("stream out_valid", {31'd0, out_valid}, 32'd1);
      check("stream result", ALUResult, sexp);
    end
    in_valid = 1'b0;
    @(negedge clk);

    // Reset in the middle of sll by 20.
    ALUControl = 4'b0100; SrcA = 32'd1; SrcB = 32'd20;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("midshift in_ready", {31'd0, in_ready}, {31'd0, !ITER});
    reset = 1'b1;
    #1;
    check("midrst out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst ALUResult", ALUResult, 32'd0);
    check("midrst Zero", {31'd0, Zero}, 32'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("midrst in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    check("midrst stays idle", {31'd0, out_valid}, 32'd0);
    do_op(4'b0000, 32'd2, 32'd3, "post-rst add", lat, rdy_seen);
    check("post-rst add result", ALUResult, 32'd5);
    check("post-rst add latency", lat, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
